vx_mem_responder: RTL and testbench

VX_MEM_RESPONDER -- requirements
Module: VX_mem_responder

---
 rtl/vx_mem_responder_if.sv | 30 +++
 rtl/vx_mem_responder.sv | 153 +++++++++++++++
 tb/tb_vx_mem_responder.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/vx_mem_responder_if.sv
// Request/response bus between a memory client (master) and the responder (slave).
interface vx_mem_responder_if #(
  parameter int DATA_WIDTH = 512,
  parameter int ADDR_WIDTH = 26,
  parameter int TAG_WIDTH  = 8
);
  logic                    mem_req_valid;
  logic                    mem_req_rw;
  logic [ADDR_WIDTH-1:0]   mem_req_addr;
  logic [DATA_WIDTH/8-1:0] mem_req_byteen;
  logic [DATA_WIDTH-1:0]   mem_req_data;
  logic [TAG_WIDTH-1:0]    mem_req_tag;
  logic                    mem_req_ready;
  logic                    mem_rsp_valid;
  logic [DATA_WIDTH-1:0]   mem_rsp_data;
  logic [TAG_WIDTH-1:0]    mem_rsp_tag;
  logic                    mem_rsp_ready;

  modport master (
    output mem_req_valid, mem_req_rw, mem_req_addr, mem_req_byteen, mem_req_data,
           mem_req_tag, mem_rsp_ready,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_tag
  );

  modport slave (
    input  mem_req_valid, mem_req_rw, mem_req_addr, mem_req_byteen, mem_req_data,
           mem_req_tag, mem_rsp_ready,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_tag
  );
endinterface

// File: rtl/vx_mem_responder.sv
// Behavioural cacheline memory responder: byte-enabled writes, fixed-latency
// reads into a credit-limited in-order response queue, activity counters.
module vx_mem_responder #(
  parameter int DATA_WIDTH      = 512,
  parameter int ADDR_WIDTH      = 26,
  parameter int TAG_WIDTH       = 8,
  parameter int DEPTH_LOG2      = 10,
  parameter int RSP_LATENCY     = 2,
  parameter int RSP_QUEUE_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  vx_mem_responder_if.slave   mem,
  output logic [31:0]         read_count,
  output logic [31:0]         write_count,
  output logic [31:0]         uninit_read_count
);
  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int LINES = 1 << DEPTH_LOG2;
  localparam int PTR_W = $clog2(RSP_QUEUE_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] QD = CNT_W'(RSP_QUEUE_DEPTH);

  logic [DATA_WIDTH-1:0] line_mem [LINES];
  logic [LINES-1:0]      written;
  logic                  ready_en;
  logic [CNT_W-1:0]      outstanding;
  logic [CNT_W-1:0]      q_count;
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [DATA_WIDTH-1:0] q_data [RSP_QUEUE_DEPTH];
  logic [TAG_WIDTH-1:0]  q_tag  [RSP_QUEUE_DEPTH];
  logic [RSP_LATENCY-1:0] vld_p;
  logic [DATA_WIDTH-1:0] data_p [RSP_LATENCY];
  logic [TAG_WIDTH-1:0]  tag_p  [RSP_LATENCY];

  logic [DEPTH_LOG2-1:0] idx;
  logic                  unused_addr_hi;
  logic [DATA_WIDTH-1:0] rd_line;
  logic                  req_fire, rd_fire, wr_fire, q_push, q_pop;

  // Upper address bits alias onto the same line.
  assign idx            = mem.mem_req_addr[DEPTH_LOG2-1:0];
  assign unused_addr_hi = ^mem.mem_req_addr[ADDR_WIDTH-1:DEPTH_LOG2];

  // Credit check counts reads still in the pipeline as well as queued ones,
  // so the queue can never overflow even though the pipeline cannot stall.
  assign mem.mem_req_ready = ready_en && (outstanding < QD);
  assign req_fire = mem.mem_req_valid && mem.mem_req_ready;
  assign rd_fire  = req_fire && !mem.mem_req_rw;
  assign wr_fire  = req_fire &&  mem.mem_req_rw;
  assign rd_line  = written[idx] ? line_mem[idx] : '0;

  assign q_push            = vld_p[RSP_LATENCY-1];
  assign mem.mem_rsp_valid = (q_count != '0);
  assign q_pop             = mem.mem_rsp_valid && mem.mem_rsp_ready;
  // Head is gated by valid so an async reset zeroes the outputs at once.
  assign mem.mem_rsp_data  = mem.mem_rsp_valid ? q_data[rd_ptr] : '0;
  assign mem.mem_rsp_tag   = mem.mem_rsp_valid ? q_tag[rd_ptr]  : '0;

  // Ready is held low during reset and enabled from the first edge after release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ready_en <= 1'b0;
    else       ready_en <= 1'b1;
  end

  // Byte-enabled line write; line data survives reset.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      for (int b = 0; b < BE_W; b++) begin
        if (mem.mem_req_byteen[b]) line_mem[idx][b*8 +: 8] <= mem.mem_req_data[b*8 +: 8];
      end
    end
  end

  // Per-line written flags, set by any accepted write (even with no byte enabled).
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        written      <= '0;
    else if (wr_fire) written[idx] <= 1'b1;
  end

  // Stage p0..pN-1: non-stalling read-latency pipeline valids.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= rd_fire;
      for (int i = 1; i < RSP_LATENCY; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  // Stage p0..pN-1: read data and tag travelling with vld_p.
  always_ff @(posedge clk) begin
    data_p[0] <= rd_line;
    tag_p[0]  <= mem.mem_req_tag;
    for (int i = 1; i < RSP_LATENCY; i++) begin
      data_p[i] <= data_p[i-1];
      tag_p[i]  <= tag_p[i-1];
    end
  end

  // Response queue storage, written from the last pipeline stage.
  always_ff @(posedge clk) begin
    if (q_push) begin
      q_data[wr_ptr] <= data_p[RSP_LATENCY-1];
      q_tag[wr_ptr]  <= tag_p[RSP_LATENCY-1];
    end
  end

  // Queue pointers, occupancy and outstanding-read credit count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      q_count     <= '0;
      outstanding <= '0;
    end else begin
      if (q_push) wr_ptr <= wr_ptr + 1'b1;
      if (q_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({q_push, q_pop})
        2'b10:   q_count <= q_count + 1'b1;
        2'b01:   q_count <= q_count - 1'b1;
        default: q_count <= q_count;
      endcase
      case ({rd_fire, q_pop})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  // Activity counters, wrapping naturally at 32 bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      read_count        <= '0;
      write_count       <= '0;
      uninit_read_count <= '0;
    end else begin
      if (rd_fire)                  read_count        <= read_count + 32'd1;
      if (wr_fire)                  write_count       <= write_count + 32'd1;
      if (rd_fire && !written[idx]) uninit_read_count <= uninit_read_count + 32'd1;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(q_push && !q_pop && (q_count == QD)))
    else $error("vx_mem_responder: response queue overflow");

  a_no_underflow: assert property (@(posedge clk) disable iff (reset)
    !(q_pop && (outstanding == '0)))
    else $error("vx_mem_responder: outstanding underflow");
endmodule

// File: tb/tb_vx_mem_responder.sv
// Self-checking bench for vx_mem_responder: directed scenarios plus a
// randomized phase, checked against a line-array/expected-queue model.
module tb_vx_mem_responder;
  localparam int DW  = 512;
  localparam int AW  = 26;
  localparam int TW  = 8;
  localparam int DL  = 10;
  localparam int LAT = 2;
  localparam int QD  = 4;
  localparam int BW  = DW / 8;

  logic clk = 1'b0;
  logic reset;
  logic [31:0] read_count, write_count, uninit_read_count;

  always #5 clk = ~clk;

  vx_mem_responder_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TAG_WIDTH(TW)) bus ();

  vx_mem_responder #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TAG_WIDTH(TW), .DEPTH_LOG2(DL),
    .RSP_LATENCY(LAT), .RSP_QUEUE_DEPTH(QD)
  ) dut (
    .clk(clk), .reset(reset), .mem(bus),
    .read_count(read_count), .write_count(write_count),
    .uninit_read_count(uninit_read_count)
  );

  // Reference model
  logic [DW-1:0] mdl_mem [1 << DL];
  bit            mdl_wr  [1 << DL];
  logic [DW-1:0] exp_data [$];
  logic [TW-1:0] exp_tag  [$];
  int unsigned   m_rd, m_wr, m_un;

  int n_vec;
  int n_err;
  bit rand_mode;

  task automatic check(string tag, logic [DW-1:0] obs, logic [DW-1:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_line();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < (1 << DL); i++) mdl_wr[i] = 1'b0;
    exp_data.delete();
    exp_tag.delete();
    m_rd = 0; m_wr = 0; m_un = 0;
  endtask

  task automatic check_counts(string tag);
    check({tag, "_read_count"},   read_count,        m_rd);
    check({tag, "_write_count"},  write_count,       m_wr);
    check({tag, "_uninit_count"}, uninit_read_count, m_un);
  endtask

  // Issue one request; called at posedge+1, returns at posedge+1.
  task automatic do_req(bit rw, logic [AW-1:0] a, logic [DW-1:0] d,
                        logic [BW-1:0] be, logic [TW-1:0] t);
    int budget;
    int i;
    budget = 200;
    i = int'(a[DL-1:0]);
    check("req_ready_credit", bus.mem_req_ready, (exp_tag.size() < QD));
    bus.mem_req_valid  = 1'b1;
    bus.mem_req_rw     = rw;
    bus.mem_req_addr   = a;
    bus.mem_req_data   = d;
    bus.mem_req_byteen = be;
    bus.mem_req_tag    = t;
    while (!bus.mem_req_ready && budget > 0) begin
      @(posedge clk); #1;
      if (rand_mode) bus.mem_rsp_ready = 1'($urandom);
      budget--;
    end
    check("req_ready_wait", bus.mem_req_ready, 1'b1);
    if (bus.mem_req_ready) begin
      @(posedge clk);
      if (rw) begin
        for (int b = 0; b < BW; b++) if (be[b]) mdl_mem[i][b*8 +: 8] = d[b*8 +: 8];
        mdl_wr[i] = 1'b1;
        m_wr++;
      end else begin
        exp_data.push_back(mdl_wr[i] ? mdl_mem[i] : '0);
        exp_tag.push_back(t);
        m_rd++;
        if (!mdl_wr[i]) m_un++;
      end
      #1;
    end
    bus.mem_req_valid = 1'b0;
    check_counts("req");
  endtask

  task automatic drain();
    int budget;
    budget = 100;
    bus.mem_rsp_ready = 1'b1;
    while ((exp_tag.size() != 0 || bus.mem_rsp_valid) && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    check("drain_outstanding", exp_tag.size(), 0);
    check("drain_rsp_valid", bus.mem_rsp_valid, 1'b0);
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_req_ready"}, bus.mem_req_ready, 1'b0);
    check({tag, "_rsp_valid"}, bus.mem_rsp_valid, 1'b0);
    check({tag, "_rsp_data"},  bus.mem_rsp_data,  '0);
    check({tag, "_rsp_tag"},   bus.mem_rsp_tag,   '0);
    check_counts(tag);
  endtask

  // Response monitor: every response must match the model queue head, in order.
  always @(negedge clk) begin
    if (!reset && bus.mem_rsp_valid) begin
      if (exp_tag.size() == 0) begin
        check("rsp_spurious", bus.mem_rsp_valid, 1'b0);
      end else if (bus.mem_rsp_ready) begin
        check("rsp_tag", bus.mem_rsp_tag, exp_tag[0]);
        check("rsp_data", bus.mem_rsp_data, exp_data[0]);
        void'(exp_tag.pop_front());
        void'(exp_data.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] a;
    logic [BW-1:0] be;
    n_vec = 0; n_err = 0; rand_mode = 1'b0;
    model_reset();
    reset = 1'b1;
    bus.mem_req_valid = 1'b0; bus.mem_req_rw = 1'b0; bus.mem_req_addr = '0;
    bus.mem_req_byteen = '0; bus.mem_req_data = '0; bus.mem_req_tag = '0;
    bus.mem_rsp_ready = 1'b0;

    // Power-on reset and ready release
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("por");
    reset = 1'b0;
    #1;
    check("por_ready_before_edge", bus.mem_req_ready, 1'b0);
    @(posedge clk); #1;
    check("por_ready_after_edge", bus.mem_req_ready, 1'b1);

    // Basic write then read with latency check
    bus.mem_rsp_ready = 1'b1;
    do_req(1'b1, AW'('h10), {64{8'hA5}}, '1, 8'h0);
    do_req(1'b0, AW'('h10), '0, '0, 8'h3);
    check("lat_edge0", bus.mem_rsp_valid, 1'b0);
    @(posedge clk); #1;
    check("lat_edge1", bus.mem_rsp_valid, 1'b0);
    @(posedge clk); #1;
    check("lat_edge2", bus.mem_rsp_valid, 1'b1);
    check("lat_tag", bus.mem_rsp_tag, 8'h3);
    check("lat_data", bus.mem_rsp_data, {64{8'hA5}});
    drain();

    // Partial byte-enable merge
    do_req(1'b1, AW'('h20), {64{8'h11}}, '1, 8'h0);
    do_req(1'b1, AW'('h20), {64{8'hFF}}, BW'(1), 8'h0);
    do_req(1'b0, AW'('h20), '0, '0, 8'h4);
    drain();

    // Unwritten line, zero-byteen write, aliasing
    do_req(1'b0, AW'('h7), '0, '0, 8'h5);
    do_req(1'b1, AW'('h5), rand_line(), '1, 8'h0);
    do_req(1'b0, AW'('h405), '0, '0, 8'h6);
    do_req(1'b1, AW'('h9), rand_line(), '0, 8'h0);
    do_req(1'b0, AW'('h9), '0, '0, 8'h7);
    drain();

    // Back-pressure: credit limit, head stability, ordering
    bus.mem_rsp_ready = 1'b0;
    for (int t = 0; t < 4; t++) do_req(1'b0, AW'('h10 + t * 'h10), '0, '0, TW'(t));
    check("bp_ready_low", bus.mem_req_ready, 1'b0);
    bus.mem_req_valid = 1'b1; bus.mem_req_rw = 1'b0; bus.mem_req_tag = 8'h4;
    repeat (5) begin
      @(posedge clk); #1;
      check("bp_ready_held", bus.mem_req_ready, 1'b0);
      check("bp_head_tag", bus.mem_rsp_tag, exp_tag[0]);
      check("bp_no_accept", read_count, m_rd);
    end
    bus.mem_req_valid = 1'b0;
    bus.mem_rsp_ready = 1'b1;
    do_req(1'b0, AW'('h10), '0, '0, 8'h4);
    do_req(1'b0, AW'('h20), '0, '0, 8'h5);
    drain();

    // Pre-fill the random-phase lines
    for (int i = 0; i < 16; i++) do_req(1'b1, AW'('h30 + i), rand_line(), '1, 8'h0);

    // Reset with reads pending
    bus.mem_rsp_ready = 1'b0;
    do_req(1'b0, AW'('h10), '0, '0, 8'h9);
    do_req(1'b0, AW'('h20), '0, '0, 8'hA);
    repeat (3) @(posedge clk);
    #1;
    check("pend_rsp_valid", bus.mem_rsp_valid, 1'b1);
    reset = 1'b1;
    model_reset();
    #1;
    check_reset_outputs("midrst");
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check("midrst_ready_before_edge", bus.mem_req_ready, 1'b0);
    @(posedge clk); #1;
    check("midrst_ready_after_edge", bus.mem_req_ready, 1'b1);
    repeat (6) begin
      @(posedge clk); #1;
      check("midrst_no_stale", bus.mem_rsp_valid, 1'b0);
    end
    bus.mem_rsp_ready = 1'b1;
    do_req(1'b0, AW'('h10), '0, '0, 8'hB);
    drain();

    // Randomized traffic on aliased addresses with random back-pressure
    rand_mode = 1'b1;
    repeat (300) begin
      a = AW'($urandom);
      a[DL-1:0] = DL'('h30 + $urandom_range(0, 15));
      case ($urandom_range(0, 3))
        0:       be = '0;
        1:       be = '1;
        default: be = rand_line()[BW-1:0];
      endcase
      bus.mem_rsp_ready = 1'($urandom);
      do_req(1'($urandom), a, rand_line(), be, TW'($urandom));
    end
    rand_mode = 1'b0;
    drain();
    check_counts("final");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
